// File: rtl/noc_pkg.sv
// noc_pkg: constants and types shared by the router output-port logic.
//   NOC_N_IN  : default number of input queues (local + 4 mesh directions)
//   NOC_PL    : default flit width; flits are indexed MSB-first [0:PL-1]
//   VALID_BIT : index of the valid bit inside a flit
//   flit_t    : flit type at the default width
//   port_e    : input-port index names
//   slot_e    : occupancy of the single-entry output register
//   ptr_width : width of a round-robin pointer covering n requesters
package noc_pkg;

   localparam int NOC_N_IN  = 5;
   localparam int NOC_PL    = 8;
   localparam int VALID_BIT = 0;

   typedef logic [0:NOC_PL-1] flit_t;

   typedef enum logic [2:0] {
      LOCAL = 3'd0,
      NORTH = 3'd1,
      EAST  = 3'd2,
      SOUTH = 3'd3,
      WEST  = 3'd4
   } port_e;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_e;

   // A single requester still needs a one-bit pointer.
   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/output_port_arbiter_if.sv
// output_port_arbiter_if: bundle between the input queues, the arbiter and
// the downstream link.
//   in_data   : head flit of each input queue
//   in_sel    : head of queue i is routed to this output port
//   shift_o   : one-hot pulse advancing the winning queue
//   out_data  : output register, out_data[0] is the valid bit
//   out_ready : downstream can accept a flit
//   grant_cnt : per-input grant counters (only with ARB_GRANT_CNT_EN)
// Modports: master = arbiter side, slave = queue/link side.
// Optional feature macro: ARB_GRANT_CNT_EN.
interface output_port_arbiter_if #(
   parameter int N_IN = noc_pkg::NOC_N_IN,
   parameter int PL   = noc_pkg::NOC_PL
`ifdef ARB_GRANT_CNT_EN
   ,
   parameter int CW   = 16
`endif
);

   logic [N_IN-1:0][0:PL-1] in_data;
   logic [N_IN-1:0]         in_sel;
   logic [N_IN-1:0]         shift_o;
   logic [0:PL-1]           out_data;
   logic                    out_ready;
`ifdef ARB_GRANT_CNT_EN
   logic [N_IN-1:0][CW-1:0] grant_cnt;

   modport master (
      input  in_data, in_sel, out_ready,
      output shift_o, out_data, grant_cnt
   );

   modport slave (
      output in_data, in_sel, out_ready,
      input  shift_o, out_data, grant_cnt
   );
`else
   modport master (
      input  in_data, in_sel, out_ready,
      output shift_o, out_data
   );

   modport slave (
      output in_data, in_sel, out_ready,
      input  shift_o, out_data
   );
`endif

endinterface

// File: rtl/output_port_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selector.
//   req : request vector
//   ptr : highest-priority index this cycle (0..N_IN-1)
//   gnt : one-hot grant (all zero when nothing requests)
//   win : index of the granted requester
//   any : at least one request present
module rr_picker
   import noc_pkg::*;
#(
   parameter int N_IN = NOC_N_IN,
   parameter int PW   = ptr_width(N_IN)
) (
   input  logic [N_IN-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [N_IN-1:0] gnt,
   output logic [PW-1:0]   win,
   output logic            any
);

   logic [PW:0]   sum_s;
   logic [PW-1:0] idx_s;
   logic          hit_s;

   // Walk ptr, ptr+1, ... modulo N_IN and keep only the first request seen.
   always_comb begin
      gnt   = '0;
      win   = '0;
      any   = 1'b0;
      sum_s = '0;
      idx_s = '0;
      hit_s = 1'b0;
      for (int k = 0; k < N_IN; k++) begin
         sum_s      = {1'b0, ptr} + (PW+1)'(k);
         idx_s      = (sum_s >= (PW+1)'(N_IN)) ? PW'(sum_s - (PW+1)'(N_IN))
                                                : sum_s[PW-1:0];
         hit_s      = req[idx_s] & ~any;
         gnt[idx_s] = gnt[idx_s] | hit_s;
         win        = hit_s ? idx_s : win;
         any        = any | hit_s;
      end
   end

endmodule

// File: rtl/output_port_arbiter.sv
// output_port_arbiter: shares one router output link between N_IN input
// queues. A round-robin choice among queues whose valid head flit targets
// this port loads one flit per cycle into a single-entry output register and
// pulses that queue's shift input.
//   clk : clock, all state on posedge
//   rst : synchronous active-high reset
//   bus : output_port_arbiter_if.master (in_data, in_sel, out_ready in;
//         shift_o, out_data, optional grant_cnt out)
// Optional feature macro: ARB_GRANT_CNT_EN adds saturating per-input grant
// counters of width CW on bus.grant_cnt.
module output_port_arbiter
   import noc_pkg::*;
#(
   parameter int N_IN = NOC_N_IN,
   parameter int PL   = NOC_PL
`ifdef ARB_GRANT_CNT_EN
   ,
   parameter int CW   = 16
`endif
) (
   input logic                  clk,
   input logic                  rst,
   output_port_arbiter_if.master bus
);

   localparam int PW = ptr_width(N_IN);

   logic [N_IN-1:0] req_s;
   logic [N_IN-1:0] gnt_s;
   logic [PW-1:0]   win_s;
   logic            any_s;
   slot_e           slot_s;
   logic            slot_free_s;

   logic [0:PL-1]   out_data_r;
   logic [0:PL-1]   out_data_s;
   logic [N_IN-1:0] shift_r;
   logic [N_IN-1:0] shift_s;
   logic [PW-1:0]   ptr_r;
   logic [PW-1:0]   ptr_s;

   // A queue requests only when its head is valid and routed here.
   always_comb begin
      req_s = '0;
      for (int i = 0; i < N_IN; i++) begin
         req_s[i] = bus.in_data[i][VALID_BIT] & bus.in_sel[i];
      end
   end

   rr_picker #(
      .N_IN (N_IN),
      .PW   (PW)
   ) u_picker (
      .req (req_s),
      .ptr (ptr_r),
      .gnt (gnt_s),
      .win (win_s),
      .any (any_s)
   );

   // Slot occupancy, and the load/hold/clear decision for the next edge.
   always_comb begin
      slot_s      = out_data_r[VALID_BIT] ? SLOT_FULL : SLOT_EMPTY;
      slot_free_s = 1'b0;
      out_data_s  = out_data_r;
      shift_s     = '0;
      ptr_s       = ptr_r;
      case (slot_s)
         SLOT_EMPTY: slot_free_s = 1'b1;
         // A full slot drained this cycle can be refilled on the same edge.
         SLOT_FULL:  slot_free_s = bus.out_ready;
         default:    slot_free_s = 1'b0;
      endcase
      if (slot_free_s) begin
         if (any_s) begin
            out_data_s = bus.in_data[win_s];
            shift_s    = gnt_s;
            ptr_s      = (win_s == PW'(N_IN - 1)) ? '0 : win_s + PW'(1);
         end else begin
            out_data_s = '0;
         end
      end else begin
         // Stalled: keep the flit; no grant, so the requesting queue waits.
         out_data_s = out_data_r;
      end
   end

   // Output register, shift pulse and round-robin pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_data_r <= '0;
         shift_r    <= '0;
         ptr_r      <= '0;
      end else begin
         out_data_r <= out_data_s;
         shift_r    <= shift_s;
         ptr_r      <= ptr_s;
      end
   end

   assign bus.out_data = out_data_r;
   assign bus.shift_o  = shift_r;

`ifdef ARB_GRANT_CNT_EN
   logic [N_IN-1:0][CW-1:0] cnt_r;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v == {CW{1'b1}}) ? v : v + CW'(1);
   endfunction

   // Per-input grant counters, saturating at all-ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= '0;
      end else begin
         for (int i = 0; i < N_IN; i++) begin
            if (shift_s[i]) begin
               cnt_r[i] <= sat_inc(cnt_r[i]);
            end
         end
      end
   end

   assign bus.grant_cnt = cnt_r;
`endif

endmodule

// File: tb/tb_output_port_arbiter.sv
// tb_output_port_arbiter: directed vector table plus randomized traffic
// checked against a behavioural model of the output-port arbiter.
module tb_output_port_arbiter;
   import noc_pkg::*;

   localparam int N_IN = 5;
   localparam int PL   = 8;
`ifdef ARB_GRANT_CNT_EN
   localparam int CW   = 2;
`endif

   typedef logic [N_IN-1:0][0:PL-1] data_t;

   typedef struct {
      logic            rst;
      data_t           data;
      logic [N_IN-1:0] sel;
      logic            rdy;
      logic [0:PL-1]   exp_out;
      logic [N_IN-1:0] exp_shift;
      int              exp_ptr;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int errors = 0;
   int checks = 0;

   // behavioural model state
   int              m_ptr;
   logic [0:PL-1]   m_out;
   logic [N_IN-1:0] m_shift;
   int              m_cnt [N_IN];

   vec_t vecs [22];

`ifdef ARB_GRANT_CNT_EN
   output_port_arbiter_if #(.N_IN(N_IN), .PL(PL), .CW(CW)) bus ();
   output_port_arbiter #(.N_IN(N_IN), .PL(PL), .CW(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );
`else
   output_port_arbiter_if #(.N_IN(N_IN), .PL(PL)) bus ();
   output_port_arbiter #(.N_IN(N_IN), .PL(PL)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );
`endif

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // One cycle of the arbiter's rules, stated directly from its behaviour.
   task automatic model_step(input logic r, input data_t d, input logic [N_IN-1:0] s,
                             input logic rdy);
      int  w;
      int  j;
      if (r) begin
         m_ptr   = 0;
         m_out   = '0;
         m_shift = '0;
         for (int i = 0; i < N_IN; i++) m_cnt[i] = 0;
      end else begin
         m_shift = '0;
         if (m_out[0] == 1'b0 || rdy) begin
            w = -1;
            for (int k = 0; k < N_IN; k++) begin
               j = (m_ptr + k) % N_IN;
               if (w < 0 && d[j][0] && s[j]) w = j;
            end
            if (w >= 0) begin
               m_out      = d[w];
               m_shift[w] = 1'b1;
               m_ptr      = (w + 1) % N_IN;
`ifdef ARB_GRANT_CNT_EN
               if (m_cnt[w] < (1 << CW) - 1) m_cnt[w]++;
`endif
            end else begin
               m_out = '0;
            end
         end
      end
   endtask

   task automatic apply(input logic r, input data_t d, input logic [N_IN-1:0] s,
                        input logic rdy);
      @(negedge clk);
      rst           = r;
      bus.in_data   = d;
      bus.in_sel    = s;
      bus.out_ready = rdy;
      model_step(r, d, s, rdy);
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input logic r, input data_t d, input logic [N_IN-1:0] s,
                               input logic rdy, input logic [0:PL-1] eo,
                               input logic [N_IN-1:0] es, input int ep);
      vec_t v;
      v.rst = r; v.data = d; v.sel = s; v.rdy = rdy;
      v.exp_out = eo; v.exp_shift = es; v.exp_ptr = ep;
      return v;
   endfunction

   initial begin
      data_t all_d;
      data_t rd;
      port_e pq;
      all_d = {8'h94, 8'h93, 8'h92, 8'h91, 8'h90};
      pq    = EAST;

      // reset with every queue valid
      vecs[0]  = mk(1'b1, {5{8'h8F}}, 5'h1F, 1'b1, 8'h00, 5'b00000, 0);
      vecs[1]  = mk(1'b1, {5{8'h8F}}, 5'h1F, 1'b1, 8'h00, 5'b00000, 0);
      // queue 2 streams alone
      vecs[2]  = mk(1'b0, {8'h00, 8'h00, 8'h81, 8'h00, 8'h00}, 5'b00100, 1'b1, 8'h81, 5'b00100, 3);
      vecs[3]  = mk(1'b0, {8'h00, 8'h00, 8'h82, 8'h00, 8'h00}, 5'b00100, 1'b1, 8'h82, 5'b00100, 3);
      vecs[4]  = mk(1'b0, {8'h00, 8'h00, 8'h83, 8'h00, 8'h00}, 5'b00100, 1'b1, 8'h83, 5'b00100, 3);
      // all five request from a fresh pointer
      vecs[5]  = mk(1'b1, all_d, 5'h1F, 1'b1, 8'h00, 5'b00000, 0);
      vecs[6]  = mk(1'b0, all_d, 5'h1F, 1'b1, 8'h90, 5'b00001, 1);
      vecs[7]  = mk(1'b0, all_d, 5'h1F, 1'b1, 8'h91, 5'b00010, 2);
      vecs[8]  = mk(1'b0, all_d, 5'h1F, 1'b1, 8'h92, 5'b00100, 3);
      vecs[9]  = mk(1'b0, all_d, 5'h1F, 1'b1, 8'h93, 5'b01000, 4);
      vecs[10] = mk(1'b0, all_d, 5'h1F, 1'b1, 8'h94, 5'b10000, 0);
      vecs[11] = mk(1'b0, all_d, 5'h1F, 1'b1, 8'h90, 5'b00001, 1);
      // fill with 0x85, then stall three cycles, then release
      vecs[12] = mk(1'b0, {8'h00, 8'h00, 8'h00, 8'h85, 8'h00}, 5'b00010, 1'b1, 8'h85, 5'b00010, 2);
      vecs[13] = mk(1'b0, all_d, 5'h1F, 1'b0, 8'h85, 5'b00000, 2);
      vecs[14] = mk(1'b0, all_d, 5'h1F, 1'b0, 8'h85, 5'b00000, 2);
      vecs[15] = mk(1'b0, all_d, 5'h1F, 1'b0, 8'h85, 5'b00000, 2);
      vecs[16] = mk(1'b0, all_d, 5'h1F, 1'b1, 8'h92, 5'b00100, 3);
      vecs[17] = mk(1'b0, all_d, 5'h1F, 1'b1, 8'h93, 5'b01000, 4);
      // ptr=4: queue 4 valid but unrouted, queues 0/2/3 routed but invalid
      vecs[18] = mk(1'b0, {8'h94, 8'h10, 8'h10, 8'h91, 8'h10}, 5'b01111, 1'b1, 8'h91, 5'b00010, 2);
      vecs[19] = mk(1'b0, '0, 5'h1F, 1'b1, 8'h00, 5'b00000, 2);
      vecs[20] = mk(1'b0, {8'h00, 8'h00, 8'h00, 8'h00, 8'hA0}, 5'b00001, 1'b1, 8'hA0, 5'b00001, 1);
      // reset discards the held flit
      vecs[21] = mk(1'b1, all_d, 5'h1F, 1'b1, 8'h00, 5'b00000, 0);

      bus.in_data   = '0;
      bus.in_sel    = '0;
      bus.out_ready = 1'b0;
      model_step(1'b1, '0, '0, 1'b0);

      for (int v = 0; v < 22; v++) begin
         apply(vecs[v].rst, vecs[v].data, vecs[v].sel, vecs[v].rdy);
         chk($sformatf("vec%0d out_data", v), 32'(bus.out_data), 32'(vecs[v].exp_out));
         chk($sformatf("vec%0d shift_o", v), 32'(bus.shift_o), 32'(vecs[v].exp_shift));
         chk($sformatf("vec%0d ptr", v), 32'(dut.ptr_r), 32'(vecs[v].exp_ptr));
      end

      // randomized traffic against the model
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N_IN; i++) rd[i] = PL'($urandom);
         apply(($urandom_range(0, 63) == 0), rd, N_IN'($urandom),
               ($urandom_range(0, 3) != 0));
         chk("rand out_data", 32'(bus.out_data), 32'(m_out));
         chk("rand shift_o", 32'(bus.shift_o), 32'(m_shift));
         chk("rand ptr", 32'(dut.ptr_r), 32'(m_ptr));
`ifdef ARB_GRANT_CNT_EN
         for (int i = 0; i < N_IN; i++)
            chk($sformatf("rand grant_cnt%0d", i), 32'(bus.grant_cnt[i]), 32'(m_cnt[i]));
`endif
      end

`ifdef ARB_GRANT_CNT_EN
      // queue 0 granted five times with a 2-bit counter
      apply(1'b1, '0, '0, 1'b1);
      chk("cnt reset", 32'(bus.grant_cnt[0]), 32'd0);
      for (int g = 0; g < 5; g++) begin
         apply(1'b0, {8'h00, 8'h00, 8'h00, 8'h00, 8'hC0}, 5'b00001, 1'b1);
         chk($sformatf("cnt grant%0d", g), 32'(bus.grant_cnt[0]), (g < 3) ? 32'(g + 1) : 32'd3);
      end
`endif

      if (int'(pq) != 2) $display("note: port enum ordering differs");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
